// File: rtl/frontend_command_definition_pkg.sv
// Shared front-end command definitions.
// Write-data arbiter defaults and state encoding.
package frontend_command_definition_pkg;

  localparam int WDATA_BURST_LEN = 8;
  localparam int WDATA_NUM_REQ   = 4;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_BURST
  } arb_state_t;

endpackage

// File: rtl/write_rr_picker.sv
// Rotating-priority find-first.
// Searches req_i starting at ptr_i, wrapping modulo NUM_REQ.
module write_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic               found_o,
  output logic [IW-1:0]      winner_o
);

  int idx;

  // Walk from the farthest offset down so the nearest hit wins.
  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    idx      = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr_i) + i) % NUM_REQ;
      if (req_i[idx]) begin
        found_o  = 1'b1;
        winner_o = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/write_data_arbiter.sv
// Burst-granular round-robin owner of the write-data FIFO push port.
// Zero-bubble handoff between bursts when another requester is waiting.
module write_data_arbiter
  import frontend_command_definition_pkg::*;
#(
  parameter int NUM_REQ    = WDATA_NUM_REQ,
  parameter int DATA_WIDTH = 1024,
  parameter int BURST_LEN  = WDATA_BURST_LEN
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  output logic [NUM_REQ-1:0]            o_ready,
  input  logic                          i_fifo_full,
  output logic                          o_wr_en,
  output logic [DATA_WIDTH-1:0]         o_wdata,
  output logic                          o_grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
  output logic                          o_burst_done
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_LEN);

  arb_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   gid_q, gid_d;
  logic [NUM_REQ-1:0] req;
  logic            found;
  logic [IW-1:0]   win;
  logic            beat;

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] g);
    return (g == IW'(NUM_REQ - 1)) ? '0 : g + IW'(1);
  endfunction

  // The finishing owner never re-wins at its own burst end.
  always_comb begin
    req = i_valid;
    if (state_q == ARB_BURST) req[gid_q] = 1'b0;
  end

  write_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .req_i    (req),
    .ptr_i    (rr_q),
    .found_o  (found),
    .winner_o (win)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_d         = rr_q;
    gid_d        = gid_q;
    o_ready      = '0;
    o_wr_en      = 1'b0;
    o_wdata      = '0;
    o_burst_done = 1'b0;
    beat         = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (found) begin
          gid_d   = win;
          rr_d    = rr_next(win);
          cnt_d   = '0;
          state_d = ARB_BURST;
        end
      end
      ARB_BURST: begin
        o_ready[gid_q] = !i_fifo_full;
        beat           = i_valid[gid_q] && !i_fifo_full;
        o_wr_en        = beat;
        if (beat) begin
          o_wdata = i_data[gid_q*DATA_WIDTH +: DATA_WIDTH];
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(BURST_LEN - 1)) begin
            o_burst_done = 1'b1;
            if (found) begin
              gid_d = win;
              rr_d  = rr_next(win);
            end else begin
              state_d = ARB_IDLE;
            end
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
    end
  end

  assign o_grant_valid = (state_q == ARB_BURST);
  assign o_grant_id    = gid_q;

endmodule

// File: doc/write_data_arbiter.md
Name: write_data_arbiter

Overview:
- Shares the single write-data FIFO between NUM_REQ front-end requesters.
- Each granted requester owns the FIFO write port for one complete burst of BURST_LEN beats.
- Grants rotate round-robin, so one burst's beats are never interleaved with another's.
- Sits between the front-end write ports and the write-data FIFO push side; the FIFO full flag throttles every beat.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 1024, width of one write-data beat.
- BURST_LEN, 8, beats per burst (power of two, 2..16).

Ports:
- i_clk, input, 1, the single clock.
- i_rst, input, 1, synchronous active-high reset.
- i_valid, input, NUM_REQ, per-requester "beat available".
- i_data, input, NUM_REQ*DATA_WIDTH, requester r's beat in slice [r*DATA_WIDTH +: DATA_WIDTH].
- o_ready, output, NUM_REQ, per-requester beat accepted this cycle when ANDed with i_valid.
- i_fifo_full, input, 1, write-data FIFO full flag.
- o_wr_en, output, 1, FIFO push strobe.
- o_wdata, output, DATA_WIDTH, FIFO push data.
- o_grant_valid, output, 1, a burst is in progress.
- o_grant_id, output, clog2(NUM_REQ), current owner.
- o_burst_done, output, 1, one-cycle pulse on the last beat of a burst.

Behaviour:
- Interface: one clock, i_clk. Reset i_rst is synchronous and active-high. All state is updated on the rising edge of i_clk.
- Reset values: state=IDLE, beat_cnt=0, rr_ptr=0, grant_id=0. o_ready=0, o_wr_en=0, o_grant_valid=0, o_grant_id=0, o_burst_done=0, o_wdata=0.
- State machine (IDLE, BURST):
  - IDLE, any i_valid set: pick winner g = first set bit of i_valid searching rr_ptr, rr_ptr+1, ... mod NUM_REQ. Register grant_id=g, rr_ptr=(g+1) mod NUM_REQ, beat_cnt=0, go to BURST.
  - IDLE: no beat transfers; o_ready all 0.
  - Arbitration latency is exactly 1 cycle from i_valid to the first possible push.
- BURST beat handshake (all combinational):
  - beat = i_valid[grant_id] && !i_fifo_full.
  - o_ready[grant_id] = !i_fifo_full; o_ready of all other requesters = 0.
  - o_wr_en = beat; o_wdata = slice grant_id of i_data when beat, else 0.
- BURST counting and exit:
  - On beat, beat_cnt increments.
  - On beat with beat_cnt==BURST_LEN-1: o_burst_done=1 and beat_cnt wraps to 0.
  - At that same edge, if any i_valid bit other than the current grant_id is set, re-arbitrate from the updated rr_ptr and stay in BURST with the new grant (zero-bubble handoff). Otherwise go to IDLE.
  - The finishing requester's own i_valid does not re-win in that cycle; it is considered next time from IDLE.
- o_grant_valid = (state==BURST); o_grant_id = grant_id.
- Boundary conditions:
  - i_fifo_full held: no push, beat_cnt frozen, grant held indefinitely; no timeout.
  - Owner drops i_valid mid-burst: stall with counter held; no abort.
  - i_fifo_full and last-beat valid in the same cycle: no push, no done; the burst completes on the first non-full cycle.
  - rr_ptr wraps NUM_REQ-1 -> 0.
  - i_rst mid-burst: return to reset values on the next edge. The partial burst already pushed is not retracted; the FIFO is reset by the same system reset.
- Arithmetic: beat_cnt width clog2(BURST_LEN), natural wrap. rr_ptr and grant_id width clog2(NUM_REQ), wrap by explicit compare to NUM_REQ-1.

Decomposition:
- Shared package (frontend_command_definition_pkg): WDATA_BURST_LEN, WDATA_NUM_REQ, and the enum typedef arb_state_t {ARB_IDLE, ARB_BURST}.
- One sub-module, write_rr_picker: combinational rotating-priority find-first. Inputs are the request vector and the priority pointer; outputs are found and winner index. Instantiated once.

Test Plan:
- Single requester 2 streams 8 beats, FIFO never full -> grant_id=2 one cycle after i_valid; 8 consecutive o_wr_en; o_burst_done on the 8th beat; IDLE the cycle after.
- Requesters 0,1,3 valid continuously -> burst order 0,1,3,0,...; no idle cycle between bursts; no beats interleaved within a burst.
- i_fifo_full asserted after beat 3 for 5 cycles -> no o_wr_en, beat_cnt holds at 3; resumes with beat 4; done after 8 total pushes.
- Owner deasserts i_valid for 2 cycles mid-burst while requester 1 is valid -> no grant change; requester 1 served only after done.
- i_rst pulsed during beat 5 -> next cycle all outputs 0 and state IDLE; new request from requester 3 granted with rr_ptr starting at 0.
- Scoreboard check over 1000 random cycles: FIFO-side beat sequence equals concatenation of whole 8-beat bursts, and each burst's data matches the per-requester queue in order.
